// File: rtl/eth_frame_tx_stream.sv
// Cut-through Ethernet frame transmitter: header fields are latched at start, the payload
// streams straight through one output register, short payloads are padded and CRC-32 FCS appended.
module eth_frame_tx_stream #(
   parameter int MIN_PAYLOAD = 46,
   parameter int MAX_PAYLOAD = 1500,
   parameter int IFG_BYTES   = 12,
   parameter int PREAMBLE_EN = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [47:0] dest_mac,
   input  logic [47:0] src_mac,
   input  logic [15:0] ether_type,
   input  logic        vlan_en,
   input  logic [15:0] vlan_tci,
   output logic        busy,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   input  logic        s_last,
   output logic        s_ready,
   output logic [7:0]  m_data,
   output logic        m_valid,
   output logic        m_sop,
   output logic        m_eop,
   input  logic        m_ready,
   output logic        frame_done,
   output logic        oversize_err,
   output logic [31:0] frame_count
);
   localparam logic [10:0] MIN_P    = 11'(MIN_PAYLOAD);
   localparam logic [10:0] MAX_P    = 11'(MAX_PAYLOAD);
   localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_PRE, S_SFD, S_DA, S_SA, S_VLAN, S_TYPE,
      S_PAY, S_DRAIN, S_PAD, S_FCS, S_IFG
   } state_t;

   state_t      state;
   state_t      hdr_next;
   logic [2:0]  bcnt;
   logic [10:0] pcnt;
   logic [10:0] pcnt_inc;
   logic [7:0]  icnt;
   logic [31:0] crc;
   logic [47:0] da_reg;
   logic [47:0] sa_reg;
   logic [15:0] type_reg;
   logic [15:0] tci_reg;
   logic        vlan_reg;
   logic [7:0]  hdr_byte;
   logic        byte_last;
   logic        slot_free;

   function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
      logic [31:0] c;
      c = crc_in;
      for (int i = 0; i < 8; i++) begin
         c = (c[0] ^ data[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction

   assign slot_free = !m_valid || m_ready;
   assign pcnt_inc  = pcnt + 11'd1;
   assign s_ready   = (state == S_PAY && slot_free) || (state == S_DRAIN);

   // Byte source for every fixed-length state, plus where that state goes after its last byte.
   always_comb begin
      hdr_byte  = 8'h00;
      byte_last = 1'b0;
      hdr_next  = state;
      case (state)
         S_PRE: begin
            hdr_byte  = 8'h55;
            byte_last = (bcnt == 3'd6);
            hdr_next  = S_SFD;
         end
         S_SFD: begin
            hdr_byte  = 8'hD5;
            byte_last = 1'b1;
            hdr_next  = S_DA;
         end
         S_DA: begin
            hdr_byte  = 8'(da_reg >> {3'd5 - bcnt, 3'b000});
            byte_last = (bcnt == 3'd5);
            hdr_next  = S_SA;
         end
         S_SA: begin
            hdr_byte  = 8'(sa_reg >> {3'd5 - bcnt, 3'b000});
            byte_last = (bcnt == 3'd5);
            hdr_next  = vlan_reg ? S_VLAN : S_TYPE;
         end
         S_VLAN: begin
            case (bcnt[1:0])
               2'd0:    hdr_byte = 8'h81;
               2'd1:    hdr_byte = 8'h00;
               2'd2:    hdr_byte = tci_reg[15:8];
               default: hdr_byte = tci_reg[7:0];
            endcase
            byte_last = (bcnt == 3'd3);
            hdr_next  = S_TYPE;
         end
         S_TYPE: begin
            hdr_byte  = bcnt[0] ? type_reg[7:0] : type_reg[15:8];
            byte_last = (bcnt == 3'd1);
            hdr_next  = S_PAY;
         end
         S_FCS: begin
            hdr_byte  = 8'(~crc >> {bcnt[1:0], 3'b000});
            byte_last = (bcnt == 3'd3);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         bcnt         <= '0;
         pcnt         <= '0;
         icnt         <= '0;
         crc          <= '0;
         da_reg       <= '0;
         sa_reg       <= '0;
         type_reg     <= '0;
         tci_reg      <= '0;
         vlan_reg     <= 1'b0;
         m_data       <= '0;
         m_valid      <= 1'b0;
         m_sop        <= 1'b0;
         m_eop        <= 1'b0;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
         oversize_err <= 1'b0;
         frame_count  <= '0;
      end else begin
         frame_done   <= 1'b0;
         oversize_err <= 1'b0;
         // An emptied slot goes invalid unless a state below loads a new byte into it.
         if (slot_free) begin
            m_valid <= 1'b0;
            m_sop   <= 1'b0;
            m_eop   <= 1'b0;
         end
         case (state)
            S_IDLE: begin
               if (start) begin
                  da_reg   <= dest_mac;
                  sa_reg   <= src_mac;
                  type_reg <= ether_type;
                  tci_reg  <= vlan_tci;
                  vlan_reg <= vlan_en;
                  crc      <= 32'hFFFFFFFF;
                  busy     <= 1'b1;
                  bcnt     <= '0;
                  pcnt     <= '0;
                  state    <= (PREAMBLE_EN != 0) ? S_PRE : S_DA;
               end
            end
            S_PRE, S_SFD, S_DA, S_SA, S_VLAN, S_TYPE: begin
               if (slot_free) begin
                  m_data  <= hdr_byte;
                  m_valid <= 1'b1;
                  m_sop   <= (bcnt == 3'd0) &&
                             (state == S_PRE || (state == S_DA && PREAMBLE_EN == 0));
                  if (state != S_PRE && state != S_SFD) crc <= crc32_byte(crc, hdr_byte);
                  if (byte_last) begin
                     bcnt  <= '0;
                     state <= hdr_next;
                  end else begin
                     bcnt <= bcnt + 3'd1;
                  end
               end
            end
            S_PAY: begin
               if (s_valid && slot_free) begin
                  m_data  <= s_data;
                  m_valid <= 1'b1;
                  crc     <= crc32_byte(crc, s_data);
                  pcnt    <= pcnt_inc;
                  if (s_last) begin
                     state <= (pcnt_inc < MIN_P) ? S_PAD : S_FCS;
                     bcnt  <= '0;
                  end else if (pcnt_inc == MAX_P) begin
                     oversize_err <= 1'b1;
                     state        <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (s_valid && s_last) begin
                  state <= S_FCS;
                  bcnt  <= '0;
               end
            end
            S_PAD: begin
               if (slot_free) begin
                  m_data  <= 8'h00;
                  m_valid <= 1'b1;
                  crc     <= crc32_byte(crc, 8'h00);
                  pcnt    <= pcnt_inc;
                  if (pcnt_inc == MIN_P) begin
                     state <= S_FCS;
                     bcnt  <= '0;
                  end
               end
            end
            S_FCS: begin
               // bcnt==4 means the eop byte is loaded and waiting to be taken downstream.
               if (bcnt == 3'd4) begin
                  if (m_ready) begin
                     state <= S_IFG;
                     icnt  <= '0;
                  end
               end else if (slot_free) begin
                  m_data  <= hdr_byte;
                  m_valid <= 1'b1;
                  m_eop   <= byte_last;
                  bcnt    <= bcnt + 3'd1;
               end
            end
            S_IFG: begin
               if (icnt == IFG_LAST) begin
                  frame_done  <= 1'b1;
                  frame_count <= frame_count + 32'd1;
                  busy        <= 1'b0;
                  state       <= S_IDLE;
               end else begin
                  icnt <= icnt + 8'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_eth_frame_tx_stream.sv
// Directed/randomized bench for eth_frame_tx_stream; expected frames come from a byte-list
// model with a table-driven CRC-32.
module tb_eth_frame_tx_stream;
   localparam int MIN_PAYLOAD = 46;
   localparam int MAX_PAYLOAD = 1500;
   localparam int IFG_BYTES   = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0;
   logic        start_a = 1'b0, start_b = 1'b0;
   logic [47:0] dest_mac = '0, src_mac = '0;
   logic [15:0] ether_type = '0, vlan_tci = '0;
   logic        vlan_en = 1'b0;
   logic [7:0]  s_data = '0;
   logic        s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
   logic        sel = 1'b0;

   logic        busy_a, s_ready_a, m_valid_a, m_sop_a, m_eop_a, frame_done_a, oversize_err_a;
   logic [7:0]  m_data_a;
   logic [31:0] frame_count_a;
   logic        busy_b, s_ready_b, m_valid_b, m_sop_b, m_eop_b, frame_done_b, oversize_err_b;
   logic [7:0]  m_data_b;
   logic [31:0] frame_count_b;

   eth_frame_tx_stream #(.MIN_PAYLOAD(MIN_PAYLOAD), .MAX_PAYLOAD(MAX_PAYLOAD),
                         .IFG_BYTES(IFG_BYTES), .PREAMBLE_EN(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start_a), .dest_mac(dest_mac), .src_mac(src_mac),
      .ether_type(ether_type), .vlan_en(vlan_en), .vlan_tci(vlan_tci), .busy(busy_a),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready_a),
      .m_data(m_data_a), .m_valid(m_valid_a), .m_sop(m_sop_a), .m_eop(m_eop_a),
      .m_ready(m_ready), .frame_done(frame_done_a), .oversize_err(oversize_err_a),
      .frame_count(frame_count_a));

   eth_frame_tx_stream #(.MIN_PAYLOAD(MIN_PAYLOAD), .MAX_PAYLOAD(MAX_PAYLOAD),
                         .IFG_BYTES(IFG_BYTES), .PREAMBLE_EN(0)) dut_np (
      .clk(clk), .rst_n(rst_n), .start(start_b), .dest_mac(dest_mac), .src_mac(src_mac),
      .ether_type(ether_type), .vlan_en(vlan_en), .vlan_tci(vlan_tci), .busy(busy_b),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready_b),
      .m_data(m_data_b), .m_valid(m_valid_b), .m_sop(m_sop_b), .m_eop(m_eop_b),
      .m_ready(m_ready), .frame_done(frame_done_b), .oversize_err(oversize_err_b),
      .frame_count(frame_count_b));

   logic        busy_o, s_ready_o, m_valid_o, m_sop_o, m_eop_o, frame_done_o, oversize_o;
   logic [7:0]  m_data_o;
   logic [31:0] frame_count_o;
   assign busy_o        = sel ? busy_b : busy_a;
   assign s_ready_o     = sel ? s_ready_b : s_ready_a;
   assign m_valid_o     = sel ? m_valid_b : m_valid_a;
   assign m_sop_o       = sel ? m_sop_b : m_sop_a;
   assign m_eop_o       = sel ? m_eop_b : m_eop_a;
   assign m_data_o      = sel ? m_data_b : m_data_a;
   assign frame_done_o  = sel ? frame_done_b : frame_done_a;
   assign oversize_o    = sel ? oversize_err_b : oversize_err_a;
   assign frame_count_o = sel ? frame_count_b : frame_count_a;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] crc_tab [256];
   logic [7:0]  pay_q [$];
   logic [7:0]  exp_q [$];
   logic [7:0]  cap_q [$];
   logic [31:0] exp_fc_a = '0, exp_fc_b = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference frame: preamble, header, truncated payload, zero pad, then ~CRC LSB byte first.
   function automatic void build_expected(input bit pre);
      logic [7:0]  body [$];
      logic [31:0] c;
      int          n;
      exp_q.delete();
      if (pre) begin
         repeat (7) exp_q.push_back(8'h55);
         exp_q.push_back(8'hD5);
      end
      for (int i = 5; i >= 0; i--) body.push_back(dest_mac[8*i +: 8]);
      for (int i = 5; i >= 0; i--) body.push_back(src_mac[8*i +: 8]);
      if (vlan_en) begin
         body.push_back(8'h81);
         body.push_back(8'h00);
         body.push_back(vlan_tci[15:8]);
         body.push_back(vlan_tci[7:0]);
      end
      body.push_back(ether_type[15:8]);
      body.push_back(ether_type[7:0]);
      n = (pay_q.size() > MAX_PAYLOAD) ? MAX_PAYLOAD : pay_q.size();
      for (int i = 0; i < n; i++) body.push_back(pay_q[i]);
      for (int i = n; i < MIN_PAYLOAD; i++) body.push_back(8'h00);
      c = 32'hFFFFFFFF;
      foreach (body[i]) c = crc_tab[c[7:0] ^ body[i]] ^ (c >> 8);
      foreach (body[i]) exp_q.push_back(body[i]);
      c = ~c;
      for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
   endfunction

   task automatic rand_fields();
      dest_mac   = {$urandom(), 16'($urandom())};
      src_mac    = {$urandom(), 16'($urandom())};
      ether_type = 16'($urandom());
      vlan_en    = 1'($urandom_range(1));
      vlan_tci   = 16'($urandom());
   endtask

   task automatic fill_pay(input int n);
      pay_q.delete();
      repeat (n) pay_q.push_back(8'($urandom()));
   endtask

   task automatic run_frame(input bit use_b, input int duty, input int gap_pct, input int second_at,
                            input int reset_at, input int exp_ov, input bit contig, input string name);
      int         s_idx = 0, cyc = 0, sop_n = 0, sop_idx = -1, eop_n = 0, eop_idx = -1;
      int         eop_cyc = -1, fd_n = 0, fd_cyc = -1, ov_n = 0, first_cyc = -1;
      int         bubbles = 0, stall_err = 0, post_valid = 0, mm = -1;
      logic       busy_at_fd = 1'b1, prev_stall = 1'b0;
      logic [9:0] prev_word = '0;
      sel = use_b;
      build_expected(!use_b);
      cap_q.delete();
      if (reset_at < 0) begin
         if (use_b) exp_fc_b++; else exp_fc_a++;
      end
      @(negedge clk);
      m_ready = 1'b1;
      s_valid = 1'b0;
      if (use_b) start_b = 1'b1; else start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      check({name, "_busy_after_start"}, 64'(busy_o), 64'd1);
      while (cyc < 20000) begin
         if (reset_at >= 0 && s_idx == reset_at) begin
            rst_n   = 1'b0;
            s_valid = 1'b0;
            s_last  = 1'b0;
            m_ready = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            #1;
            check({name, "_reset_outputs"},
                  64'({busy_a, busy_b, s_ready_a, s_ready_b, m_valid_a, m_valid_b, m_sop_a, m_sop_b,
                       m_eop_a, m_eop_b, m_data_a, m_data_b, frame_done_a, frame_done_b,
                       oversize_err_a, oversize_err_b}), 64'd0);
            exp_fc_a = '0;
            exp_fc_b = '0;
            check({name, "_reset_count"}, 64'({frame_count_a, frame_count_b}), 64'd0);
            $display("frame %s: reset after %0d payload bytes, %0d bytes seen", name, s_idx, cap_q.size());
            return;
         end
         m_ready = ($urandom_range(99) < duty);
         if (s_idx < pay_q.size() && $urandom_range(99) >= gap_pct) begin
            s_valid = 1'b1;
            s_data  = pay_q[s_idx];
            s_last  = (s_idx == pay_q.size() - 1);
         end else begin
            s_valid = 1'b0;
            s_last  = 1'b0;
         end
         if (use_b) start_b = (cyc == second_at); else start_a = (cyc == second_at);
         if (cyc == 5) begin
            dest_mac   = ~dest_mac;
            src_mac    = ~src_mac;
            ether_type = ~ether_type;
            vlan_tci   = ~vlan_tci;
            vlan_en    = ~vlan_en;
         end
         #1;
         if (prev_stall && (!m_valid_o || {m_data_o, m_sop_o, m_eop_o} != prev_word)) stall_err++;
         if (m_valid_o) begin
            if (first_cyc < 0) first_cyc = cyc;
         end else if (first_cyc >= 0 && eop_n == 0) begin
            bubbles++;
         end
         if (fd_n > 0 && m_valid_o) post_valid++;
         if (m_valid_o && m_ready) begin
            cap_q.push_back(m_data_o);
            if (m_sop_o) begin sop_n++; sop_idx = cap_q.size() - 1; end
            if (m_eop_o) begin eop_n++; eop_idx = cap_q.size() - 1; eop_cyc = cyc; end
         end
         if (s_valid && s_ready_o) s_idx++;
         if (frame_done_o) begin fd_n++; fd_cyc = cyc; busy_at_fd = busy_o; end
         if (oversize_o) ov_n++;
         prev_stall = m_valid_o && !m_ready;
         prev_word  = {m_data_o, m_sop_o, m_eop_o};
         if (fd_n > 0 && cyc - fd_cyc >= 20) break;
         @(negedge clk);
         cyc++;
      end
      start_a = 1'b0;
      start_b = 1'b0;
      s_valid = 1'b0;
      if (reset_at >= 0) begin
         check({name, "_reset_reached"}, 64'(s_idx), 64'(reset_at));
         return;
      end
      for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
         if (mm < 0 && cap_q[i] !== exp_q[i]) mm = i;
      check({name, "_len"}, 64'(cap_q.size()), 64'(exp_q.size()));
      check({name, "_first_bad_byte_idx"}, 64'(mm), 64'(-1));
      check({name, "_sop"}, 64'({sop_n, sop_idx}), {32'd1, 32'd0});
      check({name, "_eop"}, 64'({eop_n, eop_idx}), {32'd1, 32'(exp_q.size() - 1)});
      check({name, "_first_byte_latency"}, 64'(first_cyc), 64'd1);
      check({name, "_ifg_clocks"}, 64'(fd_cyc - eop_cyc), 64'(IFG_BYTES + 1));
      check({name, "_frame_done_pulses"}, 64'(fd_n), 64'd1);
      check({name, "_busy_at_done"}, 64'(busy_at_fd), 64'd0);
      check({name, "_oversize_pulses"}, 64'(ov_n), 64'(exp_ov));
      check({name, "_payload_consumed"}, 64'(s_idx), 64'(pay_q.size()));
      check({name, "_stall_stability"}, 64'(stall_err), 64'd0);
      check({name, "_idle_after_done"}, 64'(post_valid), 64'd0);
      if (contig) check({name, "_contiguous"}, 64'(bubbles), 64'd0);
      check({name, "_frame_count"}, 64'(frame_count_o), 64'(use_b ? exp_fc_b : exp_fc_a));
      $display("frame %s: payload=%0d sent=%0d expected=%0d ifg=%0d count=%0d", name, pay_q.size(),
               cap_q.size(), exp_q.size(), fd_cyc - eop_cyc - 1, frame_count_o);
   endtask

   initial begin
      int          lens [5] = '{1, 45, 46, 47, 1500};
      logic [47:0] da_save;
      logic [31:0] c;
      for (int n = 0; n < 256; n++) begin
         c = 32'(n);
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
         crc_tab[n] = c;
      end

      repeat (3) @(negedge clk);
      check("reset_outputs",
            64'({busy_a, busy_b, s_ready_a, s_ready_b, m_valid_a, m_valid_b, m_sop_a, m_sop_b,
                 m_eop_a, m_eop_b, m_data_a, m_data_b, frame_done_a, frame_done_b,
                 oversize_err_a, oversize_err_b}), 64'd0);
      check("reset_frame_count", 64'({frame_count_a, frame_count_b}), 64'd0);
      rst_n = 1'b1;

      dest_mac   = 48'hFFFFFFFFFFFF;
      src_mac    = 48'h001122334455;
      ether_type = 16'h0800;
      vlan_en    = 1'b0;
      vlan_tci   = 16'h0000;
      pay_q.delete();
      for (int i = 0; i < 46; i++) pay_q.push_back(8'(i));
      run_frame(1'b0, 100, 0, -1, -1, 0, 1'b1, "min_untagged");
      check("min_untagged_len72", 64'(cap_q.size()), 64'd72);

      rand_fields();
      vlan_en  = 1'b1;
      vlan_tci = 16'h6005;
      fill_pay(10);
      run_frame(1'b0, 100, 0, -1, -1, 0, 1'b1, "vlan_short");
      check("vlan_short_len76", 64'(cap_q.size()), 64'd76);
      check("vlan_tag_bytes", 64'({cap_q[20], cap_q[21], cap_q[22], cap_q[23]}), 64'h81006005);

      rand_fields();
      fill_pay(100);
      run_frame(1'b0, 50, 30, -1, -1, 0, 1'b0, "backpressure");

      rand_fields();
      fill_pay(1502);
      run_frame(1'b0, 80, 10, -1, -1, 1, 1'b0, "oversize");

      rand_fields();
      fill_pay(50);
      da_save = dest_mac;
      run_frame(1'b1, 100, 0, 30, -1, 0, 1'b1, "no_preamble");
      check("no_preamble_first_byte", 64'(cap_q[0]), 64'(da_save[47:40]));
      sel = 1'b0;

      rand_fields();
      fill_pay(60);
      run_frame(1'b0, 100, 0, -1, 20, 0, 1'b0, "reset_mid");
      rand_fields();
      fill_pay(64);
      run_frame(1'b0, 60, 20, -1, -1, 0, 1'b0, "after_reset");

      foreach (lens[i]) begin
         rand_fields();
         fill_pay(lens[i]);
         run_frame(1'b0, 70, 20, -1, -1, 0, 1'b0, $sformatf("rand_len%0d", lens[i]));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
